// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter with runtime character format and baud divisor.
// Frames drain back-to-back; configuration is latched per frame when the head entry is popped.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DIV_W = 20,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic [1:0]       data_bits,
    input  logic             pen,
    input  logic             ohel,
    input  logic             two_stop,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             tx_en,
    input  logic             ovf_clr,
    output logic             tx,
    output logic             busy,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count,
    output logic             txrdy,
    output logic             overflow
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic             push, pop;
    logic [7:0]       head, mask;

    state_e           state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic             stop_cnt_q, stop_cnt_d;
    logic [1:0]       bits_q, bits_d;
    logic             pen_q, pen_d;
    logic             par_q, par_d;
    logic             two_q, two_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] timer_q, timer_d;
    logic             tx_q, tx_d;
    logic             tick;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign push     = wr_en && !full;
    assign head     = mem[rd_ptr_q];
    assign mask     = 8'hFF >> (2'd3 - data_bits);
    assign tick     = (timer_q == div_q - DIV_W'(1));
    assign tx       = tx_q;
    assign busy     = (state_q != StIdle);
    assign count    = count_q;
    assign txrdy    = ~full;
    assign overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
            // A dropped write wins over a simultaneous clear.
            if (wr_en && full) overflow_q <= 1'b1;
            else if (ovf_clr)  overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            bits_q     <= '0;
            pen_q      <= 1'b0;
            par_q      <= 1'b0;
            two_q      <= 1'b0;
            div_q      <= DIV_W'(1);
            timer_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            bits_q     <= bits_d;
            pen_q      <= pen_d;
            par_q      <= par_d;
            two_q      <= two_d;
            div_q      <= div_d;
            timer_q    <= timer_d;
            tx_q       <= tx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        bits_d     = bits_q;
        pen_d      = pen_q;
        par_d      = par_q;
        two_d      = two_q;
        div_d      = div_q;
        timer_d    = (state_q == StIdle || tick) ? '0 : timer_q + DIV_W'(1);
        pop        = 1'b0;
        tx_d       = 1'b1;

        unique case (state_q)
            StIdle: begin
                if (tx_en && !empty) pop = 1'b1;
            end
            StStart: begin
                if (tick) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == {1'b0, bits_q} + 3'd4) begin
                        state_d    = pen_q ? StParity : StStop;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    state_d    = StStop;
                    stop_cnt_d = 1'b0;
                end
            end
            StStop: begin
                if (tick) begin
                    if (two_q && !stop_cnt_q) stop_cnt_d = 1'b1;
                    else if (tx_en && !empty) pop = 1'b1;
                    else                      state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Popping the head starts a new frame and snapshots its format.
        if (pop) begin
            state_d = StStart;
            shift_d = head;
            bits_d  = data_bits;
            pen_d   = pen;
            two_d   = two_stop;
            par_d   = ^(head & mask) ^ ohel;
            div_d   = (baud_div == '0) ? DIV_W'(1) : baud_div;
            timer_d = '0;
        end

        unique case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo: frame formats, FIFO limits, reset.
module tb_uart_tx_fifo;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = '0;
    logic [1:0]  data_bits = 2'd3;
    logic        pen = 1'b0;
    logic        ohel = 1'b0;
    logic        two_stop = 1'b0;
    logic [19:0] baud_div = '0;
    logic        tx_en = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        tx, busy, empty, full, txrdy, overflow;
    logic [4:0]  count;

    int errors = 0;
    int checks = 0;

    uart_tx_fifo #(.DEPTH(16), .DIV_W(20)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .data_bits(data_bits), .pen(pen), .ohel(ohel), .two_stop(two_stop),
        .baud_div(baud_div), .tx_en(tx_en), .ovf_clr(ovf_clr), .tx(tx), .busy(busy),
        .empty(empty), .full(full), .count(count), .txrdy(txrdy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic write_byte(input logic [7:0] d);
        @(posedge clk); #1;
        wr_en = 1'b1;
        wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Records one frame: waits (bounded) for the start bit, samples nbits bit-times.
    task automatic capture_frame(input int nbits, input int div, output logic [15:0] bits,
                                 output int waited, output int busy_cycles, output bit hold_ok);
        bits = '0;
        waited = 0;
        busy_cycles = 0;
        hold_ok = 1'b1;
        do begin
            @(negedge clk);
            waited++;
        end while (tx !== 1'b0 && waited < 2000);
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < div; c++) begin
                if (!(b == 0 && c == 0)) @(negedge clk);
                if (busy === 1'b1) busy_cycles++;
                if (c == 0) bits[b] = tx;
                else if (tx !== bits[b]) hold_ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (txrdy !== 1'b1) begin errors++; $display("FAIL reset_txrdy: got %b want 1", txrdy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_8n1;
        logic [15:0] bits, exp;
        int waited, bc;
        bit hold;
        data_bits = 2'd3; pen = 1'b0; two_stop = 1'b0; baud_div = 20'd4; tx_en = 1'b1;
        write_byte(8'h55);
        @(negedge clk);
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL 8n1_empty_fall: got %b want 0", empty); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL 8n1_tx_early: got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL 8n1_busy_early: got %b want 0", busy); end
        capture_frame(10, 4, bits, waited, bc, hold);
        exp = {6'd0, 1'b1, 8'h55, 1'b0};
        checks++; if (waited != 1) begin errors++; $display("FAIL 8n1_latency: got %0d want 1", waited); end
        checks++; if (bits !== exp) begin errors++; $display("FAIL 8n1_bits: got %h want %h", bits, exp); end
        checks++; if (!hold) begin errors++; $display("FAIL 8n1_hold: got 0 want 1"); end
        checks++; if (bc != 40) begin errors++; $display("FAIL 8n1_busy_len: got %0d want 40", bc); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin
            errors++; $display("FAIL 8n1_end: got busy=%b tx=%b want 0/1", busy, tx);
        end
    endtask

    task automatic test_parity;
        logic [15:0] bits, exp;
        int waited, bc;
        bit hold;
        data_bits = 2'd2; pen = 1'b1; two_stop = 1'b0; baud_div = 20'd2; tx_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            ohel = (k == 1);
            write_byte(8'hA3);
            capture_frame(10, 2, bits, waited, bc, hold);
            exp = (k == 0) ? {6'd0, 1'b1, 1'b1, 7'h23, 1'b0} : {6'd0, 1'b1, 1'b0, 7'h23, 1'b0};
            checks++; if (waited > 3) begin errors++; $display("FAIL par%0d_start: got %0d want <=3", k, waited); end
            checks++; if (bits !== exp) begin errors++; $display("FAIL par%0d_bits: got %h want %h", k, bits, exp); end
            checks++; if (!hold) begin errors++; $display("FAIL par%0d_hold: got 0 want 1", k); end
            checks++; if (bc != 20) begin errors++; $display("FAIL par%0d_len: got %0d want 20", k, bc); end
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL par%0d_end: got %b want 0", k, busy); end
        end
        pen = 1'b0; ohel = 1'b0;
    endtask

    task automatic test_overflow_drain;
        logic [15:0] bits, exp;
        int waited, bc;
        bit hold;
        data_bits = 2'd3; pen = 1'b0; two_stop = 1'b0; baud_div = 20'd1; tx_en = 1'b0;
        for (int i = 0; i < 15; i++) write_byte(8'h30 + 8'(i));
        @(negedge clk);
        checks++; if (count !== 5'd15 || full !== 1'b0) begin
            errors++; $display("FAIL ovf_15: got count=%0d full=%b want 15/0", count, full);
        end
        write_byte(8'h3F);
        @(negedge clk);
        checks++; if (count !== 5'd16 || full !== 1'b1 || txrdy !== 1'b0) begin
            errors++; $display("FAIL ovf_16: got count=%0d full=%b txrdy=%b want 16/1/0", count, full, txrdy);
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
        write_byte(8'hEE);
        @(negedge clk);
        checks++; if (overflow !== 1'b1 || count !== 5'd16) begin
            errors++; $display("FAIL ovf_17: got ovf=%b count=%0d want 1/16", overflow, count);
        end
        @(posedge clk); #1; ovf_clr = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b0;
        @(negedge clk);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", overflow); end
        @(posedge clk); #1; ovf_clr = 1'b1; wr_en = 1'b1; wr_data = 8'hDD;
        @(posedge clk); #1; ovf_clr = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_setdom: got %b want 1", overflow); end
        @(posedge clk); #1; ovf_clr = 1'b1;
        @(posedge clk); #1; ovf_clr = 1'b0;
        tx_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            capture_frame(10, 1, bits, waited, bc, hold);
            exp = {6'd0, 1'b1, 8'h30 + 8'(i), 1'b0};
            if (i == 0) begin
                checks++; if (waited > 4) begin errors++; $display("FAIL drain_first: got %0d want <=4", waited); end
            end else begin
                checks++; if (waited != 1) begin errors++; $display("FAIL drain_gap%0d: got %0d want 1", i, waited); end
            end
            checks++; if (bits !== exp) begin errors++; $display("FAIL drain_bits%0d: got %h want %h", i, bits, exp); end
        end
        @(negedge clk);
        checks++; if (empty !== 1'b1 || busy !== 1'b0 || count !== 5'd0) begin
            errors++; $display("FAIL drain_end: got empty=%b busy=%b count=%0d want 1/0/0", empty, busy, count);
        end
    endtask

    task automatic test_five_two_stop;
        logic [15:0] bits;
        int waited, bc;
        bit hold;
        data_bits = 2'd0; pen = 1'b0; two_stop = 1'b1; baud_div = 20'd0; tx_en = 1'b1;
        write_byte(8'hFF);
        capture_frame(8, 1, bits, waited, bc, hold);
        checks++; if (waited > 3) begin errors++; $display("FAIL 5b2s_start: got %0d want <=3", waited); end
        checks++; if (bits !== 16'h00FE) begin errors++; $display("FAIL 5b2s_bits: got %h want 00fe", bits); end
        checks++; if (bc != 8) begin errors++; $display("FAIL 5b2s_len: got %0d want 8", bc); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || tx !== 1'b1) begin
            errors++; $display("FAIL 5b2s_end: got busy=%b tx=%b want 0/1", busy, tx);
        end
        two_stop = 1'b0;
    endtask

    task automatic test_mid_config;
        logic [15:0] bits1, bits2;
        int w1, w2, bc1, bc2;
        bit h1, h2;
        data_bits = 2'd3; pen = 1'b0; ohel = 1'b0; two_stop = 1'b0; baud_div = 20'd3; tx_en = 1'b0;
        write_byte(8'h0F);
        write_byte(8'hC4);
        @(posedge clk); #1; tx_en = 1'b1;
        fork
            capture_frame(10, 3, bits1, w1, bc1, h1);
            begin
                repeat (6) @(posedge clk);
                #1; pen = 1'b1; baud_div = 20'd5;
            end
        join
        capture_frame(11, 5, bits2, w2, bc2, h2);
        checks++; if (bits1 !== {6'd0, 1'b1, 8'h0F, 1'b0}) begin
            errors++; $display("FAIL mid_f1_bits: got %h want %h", bits1, {6'd0, 1'b1, 8'h0F, 1'b0});
        end
        checks++; if (!h1 || bc1 != 30) begin errors++; $display("FAIL mid_f1_timing: got hold=%0d busy=%0d want 1/30", h1, bc1); end
        checks++; if (w2 != 1) begin errors++; $display("FAIL mid_f2_gap: got %0d want 1", w2); end
        checks++; if (bits2 !== {5'd0, 1'b1, 1'b1, 8'hC4, 1'b0}) begin
            errors++; $display("FAIL mid_f2_bits: got %h want %h", bits2, {5'd0, 1'b1, 1'b1, 8'hC4, 1'b0});
        end
        checks++; if (!h2 || bc2 != 55) begin errors++; $display("FAIL mid_f2_timing: got hold=%0d busy=%0d want 1/55", h2, bc2); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_end: got %b want 0", busy); end
        pen = 1'b0;
    endtask

    task automatic test_reset_midframe;
        int waited, bad;
        data_bits = 2'd3; pen = 1'b0; two_stop = 1'b0; baud_div = 20'd4; tx_en = 1'b0;
        write_byte(8'h00);
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        @(posedge clk); #1; tx_en = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (tx !== 1'b0 && waited < 100);
        checks++; if (waited >= 100) begin errors++; $display("FAIL rst_start: got timeout want start bit"); end
        repeat (17) @(negedge clk);
        checks++; if (busy !== 1'b1 || tx !== 1'b0 || count !== 5'd3) begin
            errors++; $display("FAIL rst_pre: got busy=%b tx=%b count=%0d want 1/0/3", busy, tx, count);
        end
        #1 reset = 1'b1;
        #1;
        checks++; if (tx !== 1'b1 || busy !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
            errors++; $display("FAIL rst_async: got tx=%b busy=%b count=%0d empty=%b want 1/0/0/1",
                               tx, busy, count, empty);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_resume: got %0d active cycles want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_overflow_drain();
        test_five_two_stop();
        test_mid_config();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmit channel: a FIFO-buffered serialiser with runtime-selectable character length (5–8 bits), parity (none/odd/even), 1 or 2 stop bits and a runtime baud divisor. It replaces the fixed single-byte transmit path under the TramelBlaze I/O decode: the processor pushes bytes through a write strobe, and the block drains them back-to-back onto `tx`. Status outputs feed the status byte and the interrupt edge-detect logic.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `DIV_W`, 20: baud divisor width.
- `CW`, `$clog2(DEPTH)+1`: occupancy counter width (derived, not overridden).
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `wr_en`  in  1  push `wr_data` into the FIFO (single-cycle strobe).
- `wr_data`  in  8  character; only the low `data_bits+5` bits are transmitted.
- `data_bits`  in  2  character length: 00=5, 01=6, 10=7, 11=8.
- `pen`  in  1  parity enable.
- `ohel`  in  1  parity sense: 1 = odd, 0 = even.
- `two_stop`  in  1  1 = two stop bits.
- `baud_div`  in  DIV_W  clocks per bit; 0 is treated as 1.
- `tx_en`  in  1  permits new frames to start.
- `ovf_clr`  in  1  clears `overflow`.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  a frame is in progress.
- `empty`  out  1  FIFO empty.
- `full`  out  1  FIFO full.
- `count`  out  CW  FIFO occupancy, 0..DEPTH.
- `txrdy`  out  1  equals `~full`.
- `overflow`  out  1  sticky; a write was dropped.

## Operation
- Reset values: `tx`=1, `busy`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0, `txrdy`=1. Pointers are cleared and the FSM goes to IDLE.
- FIFO push:
  - A write is accepted when `wr_en && !full`.
  - `full` is evaluated before any same-cycle pop. A write while full is dropped even if a pop occurs in the same cycle, and it sets `overflow`.
- `overflow` is set-dominant: a drop coinciding with `ovf_clr` leaves it at 1.
- Pointers wrap modulo DEPTH. `count` increments on push, decrements on pop, and is unchanged when both happen in the same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when `tx_en && !empty`. In that cycle the head entry is popped into the shift register, and `data_bits`, `pen`, `ohel`, `two_stop` and `baud_div` are latched.
  - Latched values are held for the whole frame. Config changes mid-frame do not affect it.
  - START drives `tx`=0 for one bit time, then goes to DATA.
  - DATA shifts LSB first for N = `data_bits`+5 bits.
  - After DATA, go to PARITY if `pen`=1, otherwise STOP.
  - Parity is computed over the N transmitted bits only. The parity bit = XOR of the bits if even, its inverse if odd.
  - STOP drives `tx`=1 for 1 or 2 bit times. At the end of STOP: if `tx_en && !empty`, pop and go to START directly (no idle gap); otherwise go to IDLE.
- Bit timer:
  - Counts 0..`div_l`−1; the bit advances on terminal count.
  - `div_l` = the latched `baud_div`, or 1 if the latched value was 0.
- `tx_en` falling mid-frame does not abort the frame; it only blocks the next start.
- `busy` = 1 in every state except IDLE.

## Timing
- `wr_en` in cycle N, FIFO empty, IDLE, `tx_en`=1:
  - `empty` falls at N+1.
  - Pop and latch happen in N+1.
  - `tx` falls and `busy` rises at N+2.
  - `empty` returns to 1 at N+2.
- Frame length = (1 + N + `pen` + 1 + `two_stop`) × `div_l` clocks.
- `tx` is registered, so there are no glitches.
- For back-to-back frames, the next start bit's first cycle immediately follows the last stop cycle.
- `busy` falls in the cycle after the last stop cycle when no further pop occurs.
- Asynchronous reset mid-frame: `tx`=1 immediately, FIFO contents are discarded, and no partial frame resumes.

## Test plan
- 8N1, `baud_div`=4, write 8'h55:
  - `tx` = 0,1,0,1,0,1,0,1,0,1, each held 4 clocks.
  - `busy` high for exactly 40 clocks.
  - `tx` falls 2 cycles after `wr_en`.
- 7 data bits, `pen`=1, `ohel`=0, `baud_div`=2, write 8'hA3:
  - Data bits = 1,1,0,0,0,1,0; parity bit = 1; 1 stop bit; 20 clocks total.
  - Repeat with `ohel`=1: parity bit = 0.
- `tx_en`=0, 17 writes:
  - `full`=1 and `count`=16 after the 16th write.
  - The 17th write is dropped and `overflow`=1.
  - `ovf_clr` pulse → `overflow`=0.
  - Raise `tx_en`: 16 frames drain with no idle gaps, in order; `empty`=1 at the end.
- 5 data bits, `two_stop`=1, `baud_div`=0, write 8'hFF:
  - `tx` = 0,1,1,1,1,1,1,1; 8 clocks.
  - Bit 5–7 values are never transmitted.
- Mid-frame config change: during frame 1 (8N1, div 3) switch to `pen`=1, `baud_div`=5. Frame 1 completes at div 3 with no parity; frame 2 uses div 5 with parity.
- Assert `reset` during data bit 3 with 3 entries queued:
  - `tx`=1, `count`=0, `busy`=0 asynchronously.
  - After release, no further frames are sent.
